// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_B  = 3'd0,
    OP_H  = 3'd1,
    OP_W  = 3'd2,
    OP_BU = 3'd4,
    OP_HU = 3'd5
  } mem_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StMerge,
    StWrite,
    StResp
  } lsu_state_t;

  // Unsigned widths only make sense for loads.
  function automatic logic is_legal(input logic [2:0] op, input logic store);
    case (op)
      OP_B, OP_H, OP_W: is_legal = 1'b1;
      OP_BU, OP_HU:     is_legal = !store;
      default:          is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_H, OP_HU: is_misaligned = addr_lo[0];
      OP_W:        is_misaligned = |addr_lo;
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction/extension for loads and sub-word merge for stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    case (op_i)
      OP_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      OP_BU:   load_o = {24'h0, byte_sel};
      OP_H:    load_o = {{16{half_sel[15]}}, half_sel};
      OP_HU:   load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    case (op_i)
      OP_B: merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      OP_H: begin
        if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
        else              merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator on a word-only memory, with
// read-modify-write for sub-word stores and a per-access watchdog.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_store,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic [31:0] in_addr,
  output logic [31:0] in_data,
  output logic        in_valid,
  input  logic        in_ready,
  output logic [31:0] out_addr,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] out_data
);

  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  lsu_state_t  state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [31:0] in_addr_q, in_addr_d;
  logic [31:0] in_data_q, in_data_d;
  logic        in_valid_q, in_valid_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [2:0]  op_q, op_d;
  logic        store_q, store_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [31:0] load_word, merge_word;
  logic        timed_out;

  lsu_lane_align u_lane_align (
    .op_i     (op_q),
    .addr_lo_i(addr_q[1:0]),
    .word_i   (out_data),
    .wdata_i  (wdata_q),
    .load_o   (load_word),
    .merge_o  (merge_word)
  );

  assign timed_out = (TIMEOUT != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_data_d  = '0;
    in_addr_d   = in_addr_q;
    in_data_d   = in_data_q;
    in_valid_d  = in_valid_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    op_d        = op_q;
    store_d     = store_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          op_d        = cmd_op;
          store_d     = cmd_store;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          cnt_d       = '0;
          if (!is_legal(cmd_op, cmd_store) || is_misaligned(cmd_op, cmd_addr[1:0])) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else if (cmd_store && (cmd_op == OP_W)) begin
            state_d    = StWrite;
            in_addr_d  = {cmd_addr[31:2], 2'b00};
            in_data_d  = cmd_wdata;
            in_valid_d = 1'b1;
          end else begin
            state_d     = StRead;
            out_addr_d  = {cmd_addr[31:2], 2'b00};
            out_valid_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // Merge is resolved here so the MERGE cycle only launches the write.
          word_d      = merge_word;
          if (store_q) begin
            state_d = StMerge;
          end else begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_data_d  = load_word;
          end
        end else if (timed_out) begin
          out_valid_d = 1'b0;
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StMerge: begin
        state_d    = StWrite;
        in_addr_d  = {addr_q[31:2], 2'b00};
        in_data_d  = word_q;
        in_valid_d = 1'b1;
        cnt_d      = '0;
      end
      StWrite: begin
        if (in_ready) begin
          in_valid_d  = 1'b0;
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end else if (timed_out) begin
          in_valid_d  = 1'b0;
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
        in_valid_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
      in_addr_q   <= '0;
      in_data_q   <= '0;
      in_valid_q  <= 1'b0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      store_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
      in_addr_q   <= in_addr_d;
      in_data_q   <= in_data_d;
      in_valid_q  <= in_valid_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      store_q     <= store_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_data  = rsp_data_q;
  assign in_addr   = in_addr_q;
  assign in_data   = in_data_q;
  assign in_valid  = in_valid_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vectors, corner sequences and random
// commands against a word-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_store;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_data;
  logic [31:0] in_addr, in_data, out_addr, out_data;
  logic        in_valid, in_ready, out_valid, out_ready;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_store(cmd_store),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_error(rsp_error),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_addr (out_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  int checks = 0;
  int failures = 0;

  // Memory stub state
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int stub_lat = 1;
  bit withhold = 0;
  bit spur = 0;
  int rd_wait = 0, wr_wait = 0;
  int n_rd = 0, n_wr = 0, ov_cycles = 0, proto_err = 0;
  logic prev_iv = 0, prev_ov = 0;
  logic [31:0] prev_ia = 0, prev_id = 0, prev_oa = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory that raises ready stub_lat cycles after seeing valid; writes land when ready rises.
  initial begin
    forever begin
      @(negedge clk);
      if (in_valid && out_valid) proto_err++;
      if ((in_valid && !prev_iv && prev_ov) || (out_valid && !prev_ov && prev_iv)) proto_err++;
      if (out_valid && prev_ov && out_addr != prev_oa) proto_err++;
      if (in_valid && prev_iv && (in_addr != prev_ia || in_data != prev_id)) proto_err++;
      if ((in_valid && in_addr[1:0] != 2'b00) || (out_valid && out_addr[1:0] != 2'b00))
        proto_err++;
      if (out_valid) ov_cycles++;
      prev_iv = in_valid; prev_ov = out_valid;
      prev_ia = in_addr; prev_id = in_data; prev_oa = out_addr;

      if (out_valid) begin
        if (!withhold && rd_wait >= stub_lat) begin
          out_ready = 1'b1;
          out_data  = mem[out_addr[7:2]];
          n_rd++;
        end else begin
          out_ready = 1'b0;
          out_data  = $urandom;
          rd_wait++;
        end
      end else begin
        out_ready = spur && ($urandom_range(0, 3) == 0);
        out_data  = $urandom;
        rd_wait   = 0;
      end

      if (in_valid) begin
        if (!withhold && wr_wait >= stub_lat) begin
          in_ready = 1'b1;
          mem[in_addr[7:2]] = in_data;
          n_wr++;
        end else begin
          in_ready = 1'b0;
          wr_wait++;
        end
      end else begin
        in_ready = spur && ($urandom_range(0, 3) == 0);
        wr_wait  = 0;
      end
    end
  end

  // Issue one command from a negedge; lat counts cycles from the acceptance edge.
  task automatic do_cmd(input logic st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] d, output logic e,
                        output int lat);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1; cmd_store = st; cmd_op = op; cmd_addr = a; cmd_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    d = rsp_data;
    e = rsp_error;
    if (!rsp_valid) lat = -1;
  endtask

  // Specification-level model: kind 0 = error, 1 = single access, 2 = read-modify-write.
  task automatic ref_cmd(input bit st, input int op, input int unsigned a, input logic [31:0] wd,
                         output logic [31:0] d, output bit err, output int kind);
    int size, sh, idx;
    bit legal;
    longint unsigned mask, w, v, wl, nw;
    legal = st ? (op == 0 || op == 1 || op == 2)
               : (op == 0 || op == 1 || op == 2 || op == 4 || op == 5);
    size  = (op % 4 == 0) ? 1 : (op % 4 == 1) ? 2 : 4;
    d = 32'h0; err = 1'b0; kind = 0;
    if (!legal || (a % size) != 0) begin
      err = 1'b1;
      return;
    end
    sh   = 8 * int'(a % 4);
    idx  = int'((a / 4) % 64);
    mask = (64'd1 << (8 * size)) - 1;
    w    = {32'h0, ref_mem[idx]};
    if (!st) begin
      v = (w >> sh) & mask;
      if (op < 4 && size < 4 && v >= (mask + 1) / 2) v = v + 64'hffff_ffff - mask;
      d = v[31:0];
      kind = 1;
    end else begin
      wl = {32'h0, wd};
      nw = (w & ~(mask << sh)) | ((wl & mask) << sh);
      ref_mem[idx] = nw[31:0];
      kind = (size == 4) ? 1 : 2;
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_data,
                              input logic exp_err, input int exp_lat, input int exp_rd,
                              input int exp_wr);
    vec_t v;
    v.st = st; v.op = op; v.addr = addr; v.wdata = wdata; v.exp_data = exp_data;
    v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
    return v;
  endfunction

  vec_t vecs[17];

  initial begin
    logic [31:0] d, wd;
    logic e, st;
    int lat, rd0, wr0, op, kind, exp_lat, exp_rd, exp_wr;
    int unsigned a;
    bit err, saw_rsp;
    int ops[10];

    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [31:0] d, wd, ed;
    logic e, st;
    int lat, rd0, wr0, op, kind, exp_lat, exp_rd, exp_wr;
    int unsigned a;
    bit err, saw_rsp;
    int ops[10];

    ops = '{0, 1, 2, 4, 5, 0, 1, 2, 3, 7};
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_op = 3'd0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0;
    in_ready = 1'b0; out_ready = 1'b0; out_data = 32'h0;
    repeat (3) @(negedge clk);

    chk("reset cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("reset valids", {29'h0, rsp_valid, in_valid, out_valid}, 32'h0);
    chk("reset rsp", {rsp_data[30:0], rsp_error} | {31'h0, rsp_data[31]}, 32'h0);
    chk("reset addrs", in_addr | in_data | out_addr, 32'h0);
    reset = 1'b0;

    vecs[0]  = mk(1, 3'd2, 32'h24, 32'hefefefef, 32'h0,        0, 3, 0, 1);
    vecs[1]  = mk(0, 3'd2, 32'h24, 32'h0,        32'hefefefef, 0, 3, 1, 0);
    vecs[2]  = mk(1, 3'd2, 32'h20, 32'h80ff7f01, 32'h0,        0, 3, 0, 1);
    vecs[3]  = mk(0, 3'd0, 32'h21, 32'h0,        32'h0000007f, 0, 3, 1, 0);
    vecs[4]  = mk(0, 3'd0, 32'h22, 32'h0,        32'hffffffff, 0, 3, 1, 0);
    vecs[5]  = mk(0, 3'd4, 32'h23, 32'h0,        32'h00000080, 0, 3, 1, 0);
    vecs[6]  = mk(0, 3'd1, 32'h22, 32'h0,        32'hffff80ff, 0, 3, 1, 0);
    vecs[7]  = mk(0, 3'd5, 32'h20, 32'h0,        32'h00007f01, 0, 3, 1, 0);
    vecs[8]  = mk(1, 3'd2, 32'h10, 32'h87654321, 32'h0,        0, 3, 0, 1);
    vecs[9]  = mk(1, 3'd0, 32'h11, 32'h000000aa, 32'h0,        0, 6, 1, 1);
    vecs[10] = mk(0, 3'd2, 32'h10, 32'h0,        32'h8765aa21, 0, 3, 1, 0);
    vecs[11] = mk(1, 3'd1, 32'h12, 32'h00001234, 32'h0,        0, 6, 1, 1);
    vecs[12] = mk(0, 3'd2, 32'h10, 32'h0,        32'h1234aa21, 0, 3, 1, 0);
    vecs[13] = mk(0, 3'd2, 32'h22, 32'h0,        32'h0,        1, 1, 0, 0);
    vecs[14] = mk(1, 3'd1, 32'h13, 32'h5555,     32'h0,        1, 1, 0, 0);
    vecs[15] = mk(0, 3'd3, 32'h00, 32'h0,        32'h0,        1, 1, 0, 0);
    vecs[16] = mk(1, 3'd4, 32'h04, 32'h12,       32'h0,        1, 1, 0, 0);

    stub_lat = 1;
    for (int i = 0; i < 17; i++) begin
      rd0 = n_rd; wr0 = n_wr;
      do_cmd(vecs[i].st, vecs[i].op, vecs[i].addr, vecs[i].wdata, d, e, lat);
      chk($sformatf("vec%0d data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d error", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d reads", i), 32'(n_rd - rd0), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d writes", i), 32'(n_wr - wr0), 32'(vecs[i].exp_wr));
    end

    // Watchdog: memory never answers.
    withhold = 1; ov_cycles = 0; rd0 = n_rd; wr0 = n_wr;
    do_cmd(0, 3'd2, 32'h40, 32'h0, d, e, lat);
    chk("timeout error", {31'h0, e}, 32'h1);
    chk("timeout data", d, 32'h0);
    chk("timeout latency", 32'(lat), 32'd5);
    chk("timeout out_valid cycles", 32'(ov_cycles), 32'd4);
    chk("timeout no write", 32'(n_wr - wr0), 32'd0);
    @(negedge clk);
    chk("timeout cmd_ready back", {31'h0, cmd_ready}, 32'h1);

    // Reset while a write is pending.
    cmd_valid = 1'b1; cmd_store = 1'b1; cmd_op = 3'd2; cmd_addr = 32'h30; cmd_wdata = 32'h13572468;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst-in-write in_valid before", {31'h0, in_valid}, 32'h1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst-in-write in_valid after", {31'h0, in_valid}, 32'h0);
    chk("rst-in-write cmd_ready after", {31'h0, cmd_ready}, 32'h1);
    saw_rsp = rsp_valid;
    repeat (3) begin
      @(negedge clk);
      saw_rsp = saw_rsp | rsp_valid;
    end
    chk("rst-in-write no response", {31'h0, saw_rsp}, 32'h0);
    withhold = 0; stub_lat = 1;
    do_cmd(0, 3'd2, 32'h24, 32'h0, d, e, lat);
    chk("post-reset LW data", d, 32'hefefefef);
    chk("post-reset LW latency", 32'(lat), 32'd3);

    // Random commands against the model, with spurious readies while idle.
    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      mem[i] = wd;
      ref_mem[i] = wd;
    end
    spur = 1;
    for (int i = 0; i < 200; i++) begin
      st = 1'($urandom_range(0, 1));
      op = ops[$urandom_range(0, 9)];
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 4) != 0) begin
        if (op % 4 == 1) a = a & ~32'd1;
        else if (op % 4 == 2) a = a & ~32'd3;
      end
      stub_lat = $urandom_range(0, 2);
      wd = $urandom;
      ref_cmd(st, op, a, wd, ed, err, kind);
      exp_lat = (kind == 0) ? 1 : (kind == 1) ? 2 + stub_lat : 4 + 2 * stub_lat;
      exp_rd  = (kind == 0) ? 0 : (st && kind == 1) ? 0 : 1;
      exp_wr  = (kind == 0) ? 0 : (st ? 1 : 0);
      rd0 = n_rd; wr0 = n_wr;
      do_cmd(st, 3'(op), a, wd, d, e, lat);
      chk($sformatf("rnd%0d op%0d st%0d a%0h data", i, op, st, a), d, ed);
      chk($sformatf("rnd%0d error", i), {31'h0, e}, {31'h0, err});
      chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("rnd%0d reads", i), 32'(n_rd - rd0), 32'(exp_rd));
      chk($sformatf("rnd%0d writes", i), 32'(n_wr - wr0), 32'(exp_wr));
    end
    spur = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) chk($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);
    chk("memory protocol violations", 32'(proto_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
